cla_adder: RTL and testbench
============================

// Module: cla_adder
// PURPOSE
// - Registered carry-lookahead adder: sum = a + b + cin, WIDTH bits, result one clock after inputs.
// - Serves as the add stage of the shift-and-add multiplier datapath (4x4 -> 8-bit product uses WIDTH=8).
// - Partial-product accumulation feeds a as running total and b as shifted multiplicand.
// PARAMETERS
// - WIDTH  8  operand/sum width in bits; multiple of GROUP, >= GROUP
// - GROUP  4  bits per lookahead group (carry computed in parallel inside a group)
// PORTS
// - clk        in   1      rising-edge clock
// - rst_n      in   1      asynchronous, active-low reset
// - in_valid   in   1      a/b/cin are valid this cycle
// - a          in   WIDTH  operand A (unsigned)
// - b          in   WIDTH  operand B (unsigned)
// - cin        in   1      carry in
// - sum        out  WIDTH  registered (a+b+cin) mod 2^WIDTH
// - cout       out  1      registered carry out of MSB
// - out_valid  out  1      sum/cout hold a fresh result
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low (rst_n).
// - Reset: sum=0, cout=0, out_valid=0, applied immediately on rst_n low, independent of clk.
// - Latency exactly 1 cycle: inputs sampled on rising clk edge when in_valid=1; sum/cout/out_valid update on that edge.
// - in_valid=0 at an edge: sum/cout hold previous values; out_valid=0.
// - No back-pressure; a new operation accepted every cycle (throughput 1/cycle).
// - Per bit: g[i]=a[i]&b[i], p[i]=a[i]^b[i], s[i]=p[i]^c[i].
// - Per group: carries c[k+1]=g[k] | p[k]&c[k] fully expanded (no ripple within group);
//   group G/P produced; group carries resolved by a second lookahead level over group G/P.
// - cout = carry out of bit WIDTH-1; sum truncated to WIDTH bits (wrap-around, no saturation).
// - Unsigned arithmetic only; no overflow flag beyond cout.
// - X/Z on inputs while in_valid=0 must not affect outputs.
// - Reset asserted mid-operation: pending result discarded; first out_valid after release
//   corresponds to first in_valid sampled after release.
// - Combinational path a/b/cin -> sum register is purely lookahead logic; no latches, no initial blocks.
// STRUCTURE
// - cla_pkg: CLA_DEF_WIDTH=8, CLA_DEF_GROUP=4 constants; shared by multiplier and adder.
// - Sub-module cla_group (GROUP bits): inputs a,b,cin; outputs s, group generate, group propagate.
// - Top generates WIDTH/GROUP cla_group instances, a group-level lookahead unit, and the output register.
// TESTING
// - Reset: rst_n=0 with toggling inputs -> sum=0x00, cout=0, out_valid=0 asynchronously.
// - a=0x0F, b=0x01, cin=0, in_valid=1 -> next cycle sum=0x10, cout=0, out_valid=1 (cross-group carry).
// - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
// - Back-to-back: (0x03,0x05),(0x07,0x0E),(0x24,0x12) on consecutive cycles -> 0x08,0x15,0x36 on consecutive cycles.
// - in_valid=0 after a result -> sum/cout hold, out_valid=0; rst_n pulse mid-stream clears outputs.
// - 10k random a,b,cin (WIDTH=8 and WIDTH=16) -> {cout,sum} == a+b+cin one cycle later.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants for the carry-lookahead adder and the shift-and-add multiplier datapath.
package cla_pkg;

  localparam int unsigned CLA_DEF_WIDTH = 8;
  localparam int unsigned CLA_DEF_GROUP = 4;

endpackage

// File: rtl/cla_adder_if.sv
// Operand/result bundle between an add-stage client (master) and cla_adder (slave).
interface cla_adder_if
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = CLA_DEF_WIDTH
) ();

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;

  modport master (
    output in_valid, a, b, cin,
    input  sum, cout, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin,
    output sum, cout, out_valid
  );

endinterface

// File: rtl/cla_group.sv
// One lookahead group: per-bit carries fully expanded from cin, plus group generate/propagate.
module cla_group
  import cla_pkg::*;
#(
  parameter int unsigned GROUP = CLA_DEF_GROUP
) (
  input  logic [GROUP-1:0] a_i,
  input  logic [GROUP-1:0] b_i,
  input  logic             cin_i,
  output logic [GROUP-1:0] s_o,
  output logic             gg_o,
  output logic             gp_o
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP-1:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // c[k] = cin&p[0..k-1] | OR_j g[j]&p[j+1..k-1]: sum of products, no ripple chain
  always_comb begin : bit_lookahead
    logic term;
    c = '0;
    for (int unsigned k = 0; k < GROUP; k++) begin
      term = cin_i;
      for (int unsigned j = 0; j < k; j++) term = term & p[j];
      c[k] = term;
      for (int unsigned j = 0; j < k; j++) begin
        term = g[j];
        for (int unsigned m = j + 1; m < k; m++) term = term & p[m];
        c[k] = c[k] | term;
      end
    end
  end

  always_comb begin : group_gp
    logic term;
    gg_o = 1'b0;
    for (int unsigned j = 0; j < GROUP; j++) begin
      term = g[j];
      for (int unsigned m = j + 1; m < GROUP; m++) term = term & p[m];
      gg_o = gg_o | term;
    end
    gp_o = &p;
  end

  assign s_o = p ^ c;

endmodule

// File: rtl/cla_adder.sv
// Registered two-level carry-lookahead adder: {cout,sum} = a + b + cin, one cycle latency.
module cla_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = CLA_DEF_WIDTH,
  parameter int unsigned GROUP = CLA_DEF_GROUP
) (
  input logic        clk,
  input logic        rst_n,
  cla_adder_if.slave bus
);

  localparam int unsigned NG = WIDTH / GROUP;

  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG:0]      grp_c;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             valid_q;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla_group #(
      .GROUP (GROUP)
    ) u_grp (
      .a_i   (bus.a[gi*GROUP +: GROUP]),
      .b_i   (bus.b[gi*GROUP +: GROUP]),
      .cin_i (grp_c[gi]),
      .s_o   (sum_d[gi*GROUP +: GROUP]),
      .gg_o  (grp_g[gi]),
      .gp_o  (grp_p[gi])
    );
  end

  // Second lookahead level: group carries expanded over group G/P, same form as inside a group
  always_comb begin : group_lookahead
    logic term;
    grp_c    = '0;
    grp_c[0] = bus.cin;
    for (int unsigned k = 1; k <= NG; k++) begin
      term = bus.cin;
      for (int unsigned j = 0; j < k; j++) term = term & grp_p[j];
      grp_c[k] = term;
      for (int unsigned j = 0; j < k; j++) begin
        term = grp_g[j];
        for (int unsigned m = j + 1; m < k; m++) term = term & grp_p[m];
        grp_c[k] = grp_c[k] | term;
      end
    end
  end

  assign cout_d = grp_c[NG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_cla_adder.sv
// Self-checking bench for cla_adder at WIDTH=8 and WIDTH=16 (GROUP=4), scoreboard plus directed table.
module tb_cla_adder;
    import cla_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cla_adder_if #(.WIDTH(8))  if8  ();
    cla_adder_if #(.WIDTH(16)) if16 ();

    cla_adder #(.WIDTH(8),  .GROUP(4)) dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    cla_adder #(.WIDTH(16), .GROUP(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    localparam int NVEC = 10;
    vec_t tbl [NVEC];

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    logic [8:0]  q8  [$];
    logic [16:0] q16 [$];
    logic [8:0]  hold8  = '0;
    logic [16:0] hold16 = '0;
    logic        v8_drv  = 1'b0;
    logic        v16_drv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
        if8.in_valid = v;
        if8.a        = v ? a : 'x;
        if8.b        = v ? b : 'x;
        if8.cin      = v ? c : 1'bx;
        v8_drv       = v;
        if (v) q8.push_back(9'(a) + 9'(b) + 9'(c));
    endtask

    task automatic drive16(input logic v, input logic [15:0] a, input logic [15:0] b, input logic c);
        if16.in_valid = v;
        if16.a        = v ? a : 'x;
        if16.b        = v ? b : 'x;
        if16.cin      = v ? c : 1'bx;
        v16_drv       = v;
        if (v) q16.push_back(17'(a) + 17'(b) + 17'(c));
    endtask

    // Advance one edge, then compare both DUTs against the scoreboard (or held value).
    task automatic tick();
        @(posedge clk);
        #1;
        check("valid8", 32'(if8.out_valid), 32'(v8_drv));
        if (v8_drv) begin
            if (q8.size() == 0) begin
                n_total++;
                $display("FAIL sb8: scoreboard empty, got 0x%0h expected an entry", {if8.cout, if8.sum});
            end else hold8 = q8.pop_front();
        end
        check("res8", 32'({if8.cout, if8.sum}), 32'(hold8));
        check("valid16", 32'(if16.out_valid), 32'(v16_drv));
        if (v16_drv) begin
            if (q16.size() == 0) begin
                n_total++;
                $display("FAIL sb16: scoreboard empty, got 0x%0h expected an entry", {if16.cout, if16.sum});
            end else hold16 = q16.pop_front();
        end
        check("res16", 32'({if16.cout, if16.sum}), 32'(hold16));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sum8"},   32'(if8.sum),        32'h0);
        check({tag, "_cout8"},  32'(if8.cout),       32'h0);
        check({tag, "_valid8"}, 32'(if8.out_valid),  32'h0);
        check({tag, "_sum16"},  32'(if16.sum),       32'h0);
        check({tag, "_valid16"},32'(if16.out_valid), 32'h0);
    endtask

    task automatic raw_random();
        if8.in_valid  = 1'b1; if8.a  = 8'($urandom);  if8.b  = 8'($urandom);  if8.cin  = 1'($urandom);
        if16.in_valid = 1'b1; if16.a = 16'($urandom); if16.b = 16'($urandom); if16.cin = 1'($urandom);
    endtask

    initial begin
        tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[3] = '{8'h03, 8'h05, 1'b0, 8'h08, 1'b0};
        tbl[4] = '{8'h07, 8'h0E, 1'b0, 8'h15, 1'b0};
        tbl[5] = '{8'h24, 8'h12, 1'b0, 8'h36, 1'b0};
        tbl[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        tbl[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        tbl[8] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        tbl[9] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

        // Asynchronous reset with inputs toggling
        raw_random();
        #1 rst_n = 1'b0;
        #1 check_zero("rst_async");
        for (int i = 0; i < 3; i++) begin
            raw_random();
            @(posedge clk);
            #1 check_zero("rst_hold");
        end
        rst_n = 1'b1;
        drive8(1'b0, '0, '0, 1'b0);
        drive16(1'b0, '0, '0, 1'b0);
        tick();

        // Directed table, back-to-back
        for (int i = 0; i < NVEC; i++) begin
            drive8(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin);
            drive16(1'b1, 16'(tbl[i].a), 16'(tbl[i].b), tbl[i].cin);
            tick();
            check("tbl_sum8",  32'(if8.sum),  32'(tbl[i].s));
            check("tbl_cout8", 32'(if8.cout), 32'(tbl[i].co));
        end

        // Idle cycles: outputs hold, out_valid low
        for (int i = 0; i < 2; i++) begin
            drive8(1'b0, '0, '0, 1'b0);
            drive16(1'b0, '0, '0, 1'b0);
            tick();
            check("hold_sum8", 32'(if8.sum), 32'h80);
        end

        // 16-bit cross-group carry chain
        drive8(1'b0, '0, '0, 1'b0);
        drive16(1'b1, 16'hFFFF, 16'h0000, 1'b1);
        tick();
        check("w16_wrap", 32'({if16.cout, if16.sum}), 32'h10000);

        // Reset pulse mid-stream discards the pending result
        drive8(1'b1, 8'h11, 8'h22, 1'b0);
        drive16(1'b1, 16'h1234, 16'h4321, 1'b0);
        tick();
        drive8(1'b1, 8'h44, 8'h44, 1'b1);
        drive16(1'b1, 16'h5555, 16'h1111, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_zero("mid_rst");
        @(posedge clk);
        #1 check_zero("mid_rst_edge");
        rst_n = 1'b1;
        q8.delete(); q16.delete();
        hold8 = '0; hold16 = '0;
        drive8(1'b0, '0, '0, 1'b0);
        drive16(1'b0, '0, '0, 1'b0);
        tick();
        drive8(1'b1, 8'h30, 8'h0C, 1'b1);
        drive16(1'b1, 16'h0100, 16'h00FF, 1'b0);
        tick();
        check("post_rst8", 32'({if8.cout, if8.sum}), 32'h3D);

        // Random traffic on both widths, ~80% valid
        for (int i = 0; i < 10000; i++) begin
            drive8($urandom_range(0, 9) < 8, 8'($urandom), 8'($urandom), 1'($urandom));
            drive16($urandom_range(0, 9) < 8, 16'($urandom), 16'($urandom), 1'($urandom));
            tick();
        end

        drive8(1'b0, '0, '0, 1'b0);
        drive16(1'b0, '0, '0, 1'b0);
        tick();
        check("sb8_drained",  32'(q8.size()),  32'h0);
        check("sb16_drained", 32'(q16.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
